// File: rtl/sort_pkg.sv
// Shared types and width helpers for the sort job scheduler and its round-robin arbiter.
package sort_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;

    function automatic int vec_w(input int num_vals, input int size_data);
        return num_vals * size_data;
    endfunction

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at the pointer, pointer
// advances past the granted index when the advance strobe is high.
module rr_arbiter
    import sort_pkg::*;
#(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic              adv,
    output logic [N-1:0]      gnt,
    output logic [id_w(N)-1:0] gnt_idx,
    output logic [id_w(N)-1:0] ptr
);
    localparam int IW = id_w(N);

    // Second pass (indices at/after the pointer) overrides the wrapped first pass.
    always_comb begin
        gnt_idx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j] && (j < int'(ptr))) gnt_idx = IW'(j);
        end
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j] && (j >= int'(ptr))) gnt_idx = IW'(j);
        end
        gnt = '0;
        if (|req) gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sort_job_scheduler.sv
// Shares one sort engine between NUM_REQ requesters: round-robin grant, start/done handshake,
// valid/ready response. Optional watchdog enabled by defining SORT_SCHED_TIMEOUT_EN.
module sort_job_scheduler
    import sort_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int NUM_VALS    = 5,
    parameter int SIZE_DATA   = 8,
    parameter int START_CYC   = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic [NUM_REQ-1:0]                       i_req,
    input  logic [NUM_REQ*vec_w(NUM_VALS,SIZE_DATA)-1:0] i_req_data,
    output logic [NUM_REQ-1:0]                       o_gnt,
    output logic                                     o_eng_start,
    output logic [vec_w(NUM_VALS,SIZE_DATA)-1:0]     o_eng_data,
    input  logic                                     i_eng_done,
    input  logic [vec_w(NUM_VALS,SIZE_DATA)-1:0]     i_eng_data,
    output logic                                     o_rsp_valid,
    output logic [id_w(NUM_REQ)-1:0]                 o_rsp_id,
    output logic [vec_w(NUM_VALS,SIZE_DATA)-1:0]     o_rsp_data,
    output logic                                     o_rsp_err,
    input  logic                                     i_rsp_ready
);
    localparam int VW   = vec_w(NUM_VALS, SIZE_DATA);
    localparam int IW   = id_w(NUM_REQ);
    localparam int CMAX = (START_CYC > TIMEOUT_CYC) ? START_CYC : TIMEOUT_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    sched_state_t         state, nxt;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IW-1:0]        arb_idx, rr_ptr, id_q;
    logic [VW-1:0]        sel_data, rsp_data_q;
    logic [CW-1:0]        start_cnt;
    logic                 adv, tmo_hit, job_active;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (i_clk),
        .rst     (i_rst),
        .req     (i_req),
        .adv     (adv),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .ptr     (rr_ptr)
    );

    always_comb begin
        sel_data = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (arb_idx == IW'(r)) sel_data = i_req_data[r*VW +: VW];
        end
    end

    assign job_active = (state == ISSUE) || (state == WAIT);

`ifdef SORT_SCHED_TIMEOUT_EN
    logic [CW-1:0] tmo_cnt;
    logic          rsp_err_q;

    assign tmo_hit   = job_active && !i_eng_done && (tmo_cnt == CW'(TIMEOUT_CYC - 1));
    assign o_rsp_err = rsp_err_q;

    // Counter is held at zero while idle, so it starts from zero at every grant.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tmo_cnt   <= '0;
            rsp_err_q <= 1'b0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else if (job_active) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (i_eng_done)   rsp_err_q <= 1'b0;
            else if (tmo_hit) rsp_err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign o_rsp_err = 1'b0;
`endif

    always_comb begin
        nxt = state;
        adv = 1'b0;
        case (state)
            IDLE: begin
                if (|i_req) begin
                    adv = 1'b1;
                    nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (i_eng_done || tmo_hit)                  nxt = RESP;
                else if (start_cnt == CW'(START_CYC - 1))   nxt = WAIT;
            end
            WAIT: begin
                if (i_eng_done || tmo_hit) nxt = RESP;
            end
            RESP: begin
                if (i_rsp_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            o_gnt      <= '0;
            o_eng_data <= '0;
            id_q       <= '0;
            start_cnt  <= '0;
            rsp_data_q <= '0;
        end else begin
            state <= nxt;
            o_gnt <= adv ? arb_gnt : '0;
            if (adv) begin
                o_eng_data <= sel_data;
                id_q       <= arb_idx;
                start_cnt  <= '0;
            end
            if (state == ISSUE) start_cnt <= start_cnt + 1'b1;
            // On timeout the unsorted input is returned in place of engine data.
            if (job_active && (i_eng_done || tmo_hit)) begin
                rsp_data_q <= i_eng_done ? i_eng_data : o_eng_data;
            end
        end
    end

    assign o_eng_start = (state == ISSUE);
    assign o_rsp_valid = (state == RESP);
    assign o_rsp_id    = id_q;
    assign o_rsp_data  = rsp_data_q;

    ptr_hold_when_idle: assert property (@(posedge i_clk) disable iff (i_rst)
        (state == IDLE && i_req == '0) |=> $stable(rr_ptr));

endmodule

// File: tb/tb_sort_job_scheduler.sv
// Directed scoreboard bench for sort_job_scheduler; the bench itself plays the sort engine.
module tb_sort_job_scheduler;
    localparam int NUM_REQ     = 4;
    localparam int NUM_VALS    = 5;
    localparam int SIZE_DATA   = 8;
    localparam int START_CYC   = 3;
    localparam int TIMEOUT_CYC = 64;
    localparam int VW          = NUM_VALS * SIZE_DATA;

    logic                    i_clk = 1'b0;
    logic                    i_rst;
    logic [NUM_REQ-1:0]      i_req;
    logic [NUM_REQ*VW-1:0]   i_req_data;
    logic [NUM_REQ-1:0]      o_gnt;
    logic                    o_eng_start;
    logic [VW-1:0]           o_eng_data;
    logic                    i_eng_done;
    logic [VW-1:0]           i_eng_data;
    logic                    o_rsp_valid;
    logic [1:0]              o_rsp_id;
    logic [VW-1:0]           o_rsp_data;
    logic                    o_rsp_err;
    logic                    i_rsp_ready;

    logic [VW-1:0] vecs [NUM_REQ];

    typedef struct {
        int            id;
        logic [VW-1:0] data;
        logic          err;
    } rsp_t;
    rsp_t sb[$];

    int checks = 0;
    int fails  = 0;
    int rr     = 0;

    sort_job_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .NUM_VALS    (NUM_VALS),
        .SIZE_DATA   (SIZE_DATA),
        .START_CYC   (START_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_req_data  (i_req_data),
        .o_gnt       (o_gnt),
        .o_eng_start (o_eng_start),
        .o_eng_data  (o_eng_data),
        .i_eng_done  (i_eng_done),
        .i_eng_data  (i_eng_data),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_id    (o_rsp_id),
        .o_rsp_data  (o_rsp_data),
        .o_rsp_err   (o_rsp_err),
        .i_rsp_ready (i_rsp_ready)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [VW-1:0] pack5(input int a, input int b, input int c,
                                            input int d, input int e);
        return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [VW-1:0] sort_vec(input logic [VW-1:0] v);
        logic [SIZE_DATA-1:0] el [NUM_VALS];
        logic [SIZE_DATA-1:0] t;
        logic [VW-1:0]        o;
        for (int i = 0; i < NUM_VALS; i++) el[i] = v[i*SIZE_DATA +: SIZE_DATA];
        for (int i = 0; i < NUM_VALS - 1; i++) begin
            for (int j = 0; j < NUM_VALS - 1 - i; j++) begin
                if (el[j] > el[j+1]) begin
                    t = el[j]; el[j] = el[j+1]; el[j+1] = t;
                end
            end
        end
        o = '0;
        for (int i = 0; i < NUM_VALS; i++) o[i*SIZE_DATA +: SIZE_DATA] = el[i];
        return o;
    endfunction

    function automatic logic [NUM_REQ-1:0] next_gnt(input logic [NUM_REQ-1:0] req, input int p);
        logic [NUM_REQ-1:0] g;
        g = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req[(p + k) % NUM_REQ] && g == '0) g[(p + k) % NUM_REQ] = 1'b1;
        end
        return g;
    endfunction

    task automatic load_data();
        for (int r = 0; r < NUM_REQ; r++) i_req_data[r*VW +: VW] = vecs[r];
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_gnt"},       o_gnt,       0);
        check({pfx, "_eng_start"}, o_eng_start, 0);
        check({pfx, "_eng_data"},  o_eng_data,  0);
        check({pfx, "_rsp_valid"}, o_rsp_valid, 0);
        check({pfx, "_rsp_id"},    o_rsp_id,    0);
        check({pfx, "_rsp_data"},  o_rsp_data,  0);
        check({pfx, "_rsp_err"},   o_rsp_err,   0);
    endtask

    task automatic wait_gnt(input logic [NUM_REQ-1:0] expg, output int gid);
        int n;
        n = 0;
        while (o_gnt == '0 && n < 40) begin
            tick();
            n++;
        end
        check("gnt", o_gnt, expg);
        gid = 0;
        for (int r = 0; r < NUM_REQ; r++) if (expg[r]) gid = r;
        rr = (gid + 1) % NUM_REQ;
    endtask

    task automatic serve(input logic [NUM_REQ-1:0] expg, input bit drop, input int hold,
                         input bit dup_done, input bit no_done);
        int   gid;
        int   n;
        rsp_t e;
        wait_gnt(expg, gid);
        if (drop) i_req = '0;
        check("eng_data", o_eng_data, vecs[gid]);
        n = 0;
        while (o_eng_start && n < 10) begin
            tick();
            n++;
        end
        check("start_cycles", n, START_CYC);
        if (no_done) begin
            sb.push_back('{gid, vecs[gid], 1'b1});
            n = START_CYC;
            while (!o_rsp_valid && n < TIMEOUT_CYC + 10) begin
                tick();
                n++;
            end
            check("timeout_cycles", n, TIMEOUT_CYC);
        end else begin
            check("wait_no_rsp", o_rsp_valid, 0);
            i_eng_done = 1'b1;
            i_eng_data = sort_vec(vecs[gid]);
            sb.push_back('{gid, sort_vec(vecs[gid]), 1'b0});
            tick();
            i_eng_done = 1'b0;
            i_eng_data = '0;
            check("rsp_valid", o_rsp_valid, 1);
        end
        e = sb.pop_front();
        check("rsp_id",   o_rsp_id,   e.id);
        check("rsp_data", o_rsp_data, e.data);
        check("rsp_err",  o_rsp_err,  e.err);
        for (int h = 0; h < hold; h++) begin
            if (dup_done && h == 0) begin
                i_eng_done = 1'b1;
                i_eng_data = ~e.data;
            end
            tick();
            i_eng_done = 1'b0;
            i_eng_data = '0;
            check("hold_valid", o_rsp_valid, 1);
            check("hold_id",    o_rsp_id,    e.id);
            check("hold_data",  o_rsp_data,  e.data);
            check("hold_err",   o_rsp_err,   e.err);
            check("hold_gnt",   o_gnt,       0);
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        check("valid_drop", o_rsp_valid, 0);
    endtask

    initial begin
        int gid;
        i_rst       = 1'b0;
        i_req       = '0;
        i_req_data  = '0;
        i_eng_done  = 1'b0;
        i_eng_data  = '0;
        i_rsp_ready = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) vecs[r] = '0;

        // Reset state, asserted asynchronously before any clock edge
        #1 i_rst = 1'b1;
        #1 check_all_zero("reset");
        tick();
        tick();
        i_rst = 1'b0;

        // Single job
        vecs[0] = pack5(5, 3, 9, 1, 7);
        load_data();
        i_req = 4'b0001;
        serve(next_gnt(i_req, rr), 1'b1, 0, 1'b0, 1'b0);
        check("single_sorted", o_rsp_data, pack5(1, 3, 5, 7, 9));

        // Round robin with all requesters held high
        for (int r = 0; r < NUM_REQ; r++) vecs[r] = VW'({$urandom, $urandom});
        load_data();
        i_req = 4'b1111;
        repeat (5) serve(next_gnt(i_req, rr), 1'b0, 0, 1'b0, 1'b0);

        // Backpressure with a second done arriving during RESP, then the next grant
        serve(next_gnt(i_req, rr), 1'b0, 10, 1'b1, 1'b0);
        serve(next_gnt(i_req, rr), 1'b1, 0, 1'b0, 1'b0);

        // Spurious done while idle
        i_eng_done = 1'b1;
        i_eng_data = pack5(9, 9, 9, 9, 9);
        tick();
        i_eng_done = 1'b0;
        i_eng_data = '0;
        check("idle_done_valid", o_rsp_valid, 0);
        check("idle_done_start", o_eng_start, 0);
        check("idle_done_gnt",   o_gnt,       0);
        tick();
        check("idle_done_valid2", o_rsp_valid, 0);

        // Reset in the middle of WAIT
        vecs[0] = pack5(4, 8, 2, 6, 1);
        load_data();
        i_req = 4'b0001;
        wait_gnt(next_gnt(i_req, rr), gid);
        i_req = '0;
        repeat (START_CYC + 1) tick();
        check("mid_wait_start", o_eng_start, 0);
        check("mid_wait_valid", o_rsp_valid, 0);
        #2 i_rst = 1'b1;
        #1 check_all_zero("mid_reset");
        rr = 0;
        tick();
        tick();
        i_rst = 1'b0;
        i_req = 4'b0101;
        serve(next_gnt(i_req, rr), 1'b1, 0, 1'b0, 1'b0);
        i_req = 4'b0100;
        serve(next_gnt(i_req, rr), 1'b1, 0, 1'b0, 1'b0);

`ifdef SORT_SCHED_TIMEOUT_EN
        // Engine never completes; a late done must not alter the response
        vecs[0] = pack5(30, 10, 50, 20, 40);
        load_data();
        i_req = 4'b0001;
        serve(next_gnt(i_req, rr), 1'b1, 2, 1'b1, 1'b1);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
